// File: rtl/axi2spi_bridge_p.sv
// AXI4-Lite slave with a small register file driving a parametrised SPI master.
// Supports CPOL/CPHA modes, LSB/MSB-first, programmable SCLK divider and chip-select hold.
module axi2spi_bridge_p #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CS = 4,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              FCLK_CLK0,
    input  logic              RST,
    input  logic [31:0]       AXI_awaddr,
    input  logic [2:0]        AXI_awprot,
    input  logic              AXI_awvalid,
    output logic              AXI_awready,
    input  logic [31:0]       AXI_wdata,
    input  logic [3:0]        AXI_wstrb,
    input  logic              AXI_wvalid,
    output logic              AXI_wready,
    output logic [1:0]        AXI_bresp,
    output logic              AXI_bvalid,
    input  logic              AXI_bready,
    input  logic [31:0]       AXI_araddr,
    input  logic [2:0]        AXI_arprot,
    input  logic              AXI_arvalid,
    output logic              AXI_arready,
    output logic [31:0]       AXI_rdata,
    output logic [1:0]        AXI_rresp,
    output logic              AXI_rvalid,
    input  logic              AXI_rready,
    output logic              IRQ,
    output logic              o_sclk,
    output logic              o_mosi,
    input  logic              i_miso,
    output logic [NUM_CS-1:0] o_cs_n
);

    localparam int unsigned EDGE_W = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
    localparam logic [2:0] IDX_CTRL = 3'd0;
    localparam logic [2:0] IDX_STAT = 3'd1;
    localparam logic [2:0] IDX_DATA = 3'd2;
    localparam logic [2:0] IDX_DIV  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_XFER,
        ST_TRAIL
    } state_t;

    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    state_t state_q, state_d;

    logic              ctrl_en, ctrl_cpol, ctrl_cpha, ctrl_lsb, ctrl_irq_en, ctrl_cs_hold;
    logic [2:0]        ctrl_cs_sel;
    logic              en_d, cpol_d, cs_hold_d;
    logic              done_q, ovr_q, done_d, ovr_d;
    logic [DIV_W-1:0]  div_q, div_l, cnt_q;
    logic [DATA_W-1:0] tx_sr, rx_sr, rx_q;
    logic [EDGE_W-1:0] edge_q;
    logic              cpha_l, lsb_l;
    logic [2:0]        cs_sel_q, cs_sel_d, hold_sel_q, hold_sel_d;
    logic              hold_q, hold_d;
    logic [NUM_CS-1:0] cs_n_d;
    logic              done_evt;

    logic       wr_hs, rd_hs, ctrl_wr, stat_wr, data_wr, div_wr, busy, start, tick;
    logic       xfer_edge, sample_c;
    logic [2:0] wr_idx, rd_idx;
    logic [31:0] rd_word;

    logic unused_ok;
    assign unused_ok = &{1'b0, AXI_awaddr[31:5], AXI_awaddr[1:0], AXI_araddr[31:5],
                         AXI_araddr[1:0], AXI_awprot, AXI_arprot, AXI_wstrb, AXI_wdata};

    // Bus handshakes: accepted in the same cycle the ready strobes are high.
    assign wr_hs       = AXI_awvalid & AXI_wvalid & ~AXI_bvalid;
    assign rd_hs       = AXI_arvalid & ~AXI_rvalid;
    assign AXI_awready = wr_hs;
    assign AXI_wready  = wr_hs;
    assign AXI_arready = rd_hs;

    assign wr_idx  = AXI_awaddr[4:2];
    assign rd_idx  = AXI_araddr[4:2];
    assign ctrl_wr = wr_hs && (wr_idx == IDX_CTRL);
    assign stat_wr = wr_hs && (wr_idx == IDX_STAT);
    assign data_wr = wr_hs && (wr_idx == IDX_DATA);
    assign div_wr  = wr_hs && (wr_idx == IDX_DIV);

    assign busy  = (state_q != ST_IDLE);
    assign start = data_wr && ctrl_en && !busy;
    assign tick  = (cnt_q == div_l);

    assign en_d      = ctrl_wr ? AXI_wdata[0] : ctrl_en;
    assign cpol_d    = ctrl_wr ? AXI_wdata[1] : ctrl_cpol;
    assign cs_hold_d = ctrl_wr ? AXI_wdata[5] : ctrl_cs_hold;

    // DONE set beats a simultaneous write-1-to-clear.
    assign done_d = (done_q & ~(stat_wr & AXI_wdata[1])) | done_evt;
    assign ovr_d  = (ovr_q & ~(stat_wr & AXI_wdata[2])) | (data_wr & ctrl_en & busy);

    assign xfer_edge = (state_q == ST_XFER) && tick;
    assign sample_c  = (edge_q[0] == cpha_l);

    assign IRQ = done_q & ctrl_irq_en;

    always_ff @(posedge FCLK_CLK0) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Engine next state, chip-select hold tracking and next chip-select pattern.
    always_comb begin
        state_d    = state_q;
        done_evt   = 1'b0;
        hold_d     = hold_q;
        hold_sel_d = hold_sel_q;
        cs_sel_d   = start ? ctrl_cs_sel : cs_sel_q;
        cs_n_d     = '1;

        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LEAD;
            ST_LEAD:  if (tick) state_d = ST_XFER;
            ST_XFER:  if (tick && (edge_q == EDGE_LAST)) state_d = ST_TRAIL;
            ST_TRAIL: if (tick) begin
                state_d  = ST_IDLE;
                done_evt = 1'b1;
            end
            default:  state_d = ST_IDLE;
        endcase

        // Clearing EN abandons the transfer without completing it.
        if (busy && !en_d) begin
            state_d  = ST_IDLE;
            done_evt = 1'b0;
        end

        if (!cs_hold_d || !en_d) hold_d = 1'b0;
        if (start && (ctrl_cs_sel != hold_sel_q)) hold_d = 1'b0;
        if (done_evt && cs_hold_d) begin
            hold_d     = 1'b1;
            hold_sel_d = cs_sel_q;
        end

        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (((state_d != ST_IDLE) && (cs_sel_d == 3'(i))) ||
                (hold_d && (hold_sel_d == 3'(i))))
                cs_n_d[i] = 1'b0;
        end
    end

    always_comb begin
        rd_word = 32'h0;
        case (rd_idx)
            IDX_CTRL: rd_word = {21'b0, ctrl_cs_sel, 2'b0, ctrl_cs_hold, ctrl_irq_en,
                                 ctrl_lsb, ctrl_cpha, ctrl_cpol, ctrl_en};
            IDX_STAT: rd_word = {29'b0, ovr_q, done_q, busy};
            IDX_DATA: rd_word = 32'(rx_q);
            IDX_DIV:  rd_word = 32'(div_q);
            default:  rd_word = 32'h0;
        endcase
    end

    always_ff @(posedge FCLK_CLK0) begin
        if (RST) begin
            ctrl_en      <= 1'b0;
            ctrl_cpol    <= 1'b0;
            ctrl_cpha    <= 1'b0;
            ctrl_lsb     <= 1'b0;
            ctrl_irq_en  <= 1'b0;
            ctrl_cs_hold <= 1'b0;
            ctrl_cs_sel  <= 3'b0;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
            div_q        <= '0;
            div_l        <= '0;
            cnt_q        <= '0;
            edge_q       <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            rx_q         <= '0;
            cpha_l       <= 1'b0;
            lsb_l        <= 1'b0;
            cs_sel_q     <= 3'b0;
            hold_q       <= 1'b0;
            hold_sel_q   <= 3'b0;
            o_cs_n       <= '1;
            o_sclk       <= 1'b0;
            o_mosi       <= 1'b0;
            AXI_bvalid   <= 1'b0;
            AXI_bresp    <= 2'b00;
            AXI_rvalid   <= 1'b0;
            AXI_rresp    <= 2'b00;
            AXI_rdata    <= 32'h0;
        end else begin
            if (ctrl_wr) begin
                ctrl_cpha   <= AXI_wdata[2];
                ctrl_lsb    <= AXI_wdata[3];
                ctrl_irq_en <= AXI_wdata[4];
                ctrl_cs_sel <= AXI_wdata[10:8];
            end
            ctrl_en      <= en_d;
            ctrl_cpol    <= cpol_d;
            ctrl_cs_hold <= cs_hold_d;
            done_q       <= done_d;
            ovr_q        <= ovr_d;
            if (div_wr) div_q <= DIV_W'(AXI_wdata);

            cs_sel_q   <= cs_sel_d;
            hold_q     <= hold_d;
            hold_sel_q <= hold_sel_d;
            o_cs_n     <= cs_n_d;

            // Half-period counter wraps at the divider sampled at start.
            if ((state_q == ST_IDLE) || (state_d == ST_IDLE) || tick) cnt_q <= '0;
            else                                                      cnt_q <= cnt_q + DIV_W'(1);

            if (state_q == ST_IDLE)  edge_q <= '0;
            else if (xfer_edge)      edge_q <= edge_q + EDGE_W'(1);

            if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) o_sclk <= cpol_d;
            else if (xfer_edge)                                o_sclk <= ~o_sclk;

            if (start) begin
                div_l  <= div_q;
                cpha_l <= ctrl_cpha;
                lsb_l  <= ctrl_lsb;
                // CPHA=0 presents the first bit before the first clock edge.
                if (!ctrl_cpha) begin
                    o_mosi <= first_bit(DATA_W'(AXI_wdata), ctrl_lsb);
                    tx_sr  <= shift_out(DATA_W'(AXI_wdata), ctrl_lsb);
                end else begin
                    tx_sr  <= DATA_W'(AXI_wdata);
                end
            end else if (xfer_edge) begin
                if (sample_c) begin
                    rx_sr <= lsb_l ? ((rx_sr >> 1) | (DATA_W'(i_miso) << (DATA_W - 1)))
                                   : ((rx_sr << 1) | DATA_W'(i_miso));
                end else begin
                    o_mosi <= first_bit(tx_sr, lsb_l);
                    tx_sr  <= shift_out(tx_sr, lsb_l);
                end
            end

            if (done_evt) rx_q <= rx_sr;

            if (wr_hs) begin
                AXI_bvalid <= 1'b1;
                AXI_bresp  <= wr_idx[2] ? 2'b10 : 2'b00;
            end else if (AXI_bready) begin
                AXI_bvalid <= 1'b0;
            end

            if (rd_hs) begin
                AXI_rvalid <= 1'b1;
                AXI_rresp  <= rd_idx[2] ? 2'b10 : 2'b00;
                AXI_rdata  <= rd_idx[2] ? 32'h0 : rd_word;
            end else if (AXI_rready) begin
                AXI_rvalid <= 1'b0;
            end
        end
    end

endmodule
